apb_master: RTL and testbench

APB_MASTER -- requirements
Module: apb_master

---
 rtl/apb_master.sv | 116 +++++++++++
 tb/tb_apb_master.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master.sv
// APB master: accepts one host request at a time and runs it as an APB
// SETUP/ACCESS transfer, returning a one-cycle completion pulse.
// Optional ACCESS-phase watchdog is compiled in with `define APB_TIMEOUT_EN;
// without it the master waits for PREADY indefinitely and rsp_err is tied low.
module apb_master #(
  parameter int unsigned DATAWIDTH = 8,
  parameter int unsigned ADDRWIDTH = 8,
  parameter int unsigned TIMEOUT   = 15
) (
  input  logic                 PCLK,
  input  logic                 PRESET,
  // Host request/response
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [ADDRWIDTH-1:0] req_addr,
  input  logic [DATAWIDTH-1:0] req_wdata,
  output logic                 rsp_valid,
  output logic [DATAWIDTH-1:0] rsp_rdata,
  output logic                 rsp_err,
  // APB
  output logic                 PSEL,
  output logic                 PENABLE,
  output logic                 PWRITE,
  output logic [ADDRWIDTH-1:0] PADDR,
  output logic [DATAWIDTH-1:0] PWDATA,
  input  logic [DATAWIDTH-1:0] PRDATA,
  input  logic                 PREADY
);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StSetup  = 2'd1;
  localparam logic [1:0] StAccess = 2'd2;

  logic [1:0] state_q, state_d;
  logic       handshake;
  logic       done_ok;
  logic       done_err;

  assign req_ready = (state_q == StIdle);
  assign handshake = req_valid & req_ready;
  // PREADY/PRDATA only mean anything while in ACCESS.
  assign done_ok   = (state_q == StAccess) & PREADY;

`ifdef APB_TIMEOUT_EN
  logic [7:0] wait_cnt_q;

  // Abort when the current stalled cycle would be the TIMEOUT-th one.
  assign done_err = (state_q == StAccess) & ~PREADY & (wait_cnt_q == 8'(TIMEOUT - 1));

  // Count stalled ACCESS cycles; cleared whenever a new transfer enters SETUP.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      wait_cnt_q <= '0;
    end else if (state_d == StSetup) begin
      wait_cnt_q <= '0;
    end else if ((state_q == StAccess) && !PREADY) begin
      wait_cnt_q <= wait_cnt_q + 8'd1;
    end
  end

  // Error flag accompanies the completion pulse.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      rsp_err <= 1'b0;
    end else begin
      rsp_err <= done_err;
    end
  end
`else
  assign done_err = 1'b0;
  assign rsp_err  = 1'b0;
`endif

  // Next-state: SETUP always lasts one cycle, ACCESS until PREADY or abort.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:   if (handshake) state_d = StSetup;
      StSetup:  state_d = StAccess;
      StAccess: if (done_ok || done_err) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Registered APB and response outputs; reset abandons any in-flight transfer.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q   <= StIdle;
      PSEL      <= 1'b0;
      PENABLE   <= 1'b0;
      PWRITE    <= 1'b0;
      PADDR     <= '0;
      PWDATA    <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      state_q   <= state_d;
      PSEL      <= (state_d != StIdle);
      PENABLE   <= (state_d == StAccess);
      rsp_valid <= done_ok | done_err;
      if (handshake) begin
        PWRITE <= req_write;
        PADDR  <= req_addr;
        PWDATA <= req_wdata;
      end
      // rsp_rdata holds its value between completions.
      if (done_ok) begin
        rsp_rdata <= PWRITE ? '0 : PRDATA;
      end else if (done_err) begin
        rsp_rdata <= '0;
      end
    end
  end

endmodule

// File: tb/tb_apb_master.sv
// Self-checking bench for apb_master: directed scenarios plus randomized
// transfers, each checked cycle by cycle against a transfer-level timeline.
module tb_apb_master;

  localparam int unsigned DW  = 8;
  localparam int unsigned AW  = 8;
  localparam int unsigned TMO = 4;
`ifdef APB_TIMEOUT_EN
  localparam bit TmoEn = 1'b1;
`else
  localparam bit TmoEn = 1'b0;
`endif

  logic          PCLK = 1'b0;
  logic          PRESET;
  logic          req_valid, req_ready, req_write;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid, rsp_err;
  logic [DW-1:0] rsp_rdata;
  logic          PSEL, PENABLE, PWRITE, PREADY;
  logic [AW-1:0] PADDR;
  logic [DW-1:0] PWDATA, PRDATA;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Reference state: what the APB bus and response port should currently hold.
  logic          m_write;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] m_rdata;

  apb_master #(
    .DATAWIDTH(DW),
    .ADDRWIDTH(AW),
    .TIMEOUT  (TMO)
  ) dut (
    .PCLK     (PCLK),
    .PRESET   (PRESET),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_write(req_write),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err),
    .PSEL     (PSEL),
    .PENABLE  (PENABLE),
    .PWRITE   (PWRITE),
    .PADDR    (PADDR),
    .PWDATA   (PWDATA),
    .PRDATA   (PRDATA),
    .PREADY   (PREADY)
  );

  always #5 PCLK = ~PCLK;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_bus_hold();
    check_eq("paddr", 32'(PADDR), 32'(m_addr));
    check_eq("pwdata", 32'(PWDATA), 32'(m_wdata));
    check_eq("pwrite", 32'(PWRITE), 32'(m_write));
    check_eq("rsp_rdata", 32'(rsp_rdata), 32'(m_rdata));
  endtask

  task automatic check_idle(input logic exp_rsp, input logic exp_err);
    check_eq("idle_psel", 32'(PSEL), 32'd0);
    check_eq("idle_penable", 32'(PENABLE), 32'd0);
    check_eq("idle_req_ready", 32'(req_ready), 32'd1);
    check_eq("rsp_valid", 32'(rsp_valid), 32'(exp_rsp));
    if (exp_rsp) check_eq("rsp_err", 32'(rsp_err), 32'(exp_err));
    check_bus_hold();
  endtask

  task automatic scramble_slave();
    PREADY = 1'($urandom);
    PRDATA = DW'($urandom);
  endtask

  task automatic scramble_req();
    req_write = 1'($urandom);
    req_addr  = AW'($urandom);
    req_wdata = DW'($urandom);
  endtask

  // Called at a negedge with the DUT idle; leaves the bench at a negedge.
  task automatic idle_cycle();
    req_valid = 1'b0;
    scramble_req();
    scramble_slave();
    @(posedge PCLK);
    @(negedge PCLK);
    check_idle(1'b0, 1'b0);
  endtask

  // One transfer: slave stalls w ACCESS cycles, then returns prd. Called at a
  // negedge of an IDLE cycle; returns at the negedge of the response cycle.
  task automatic txn(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                     input int w, input logic [DW-1:0] prd);
    int   acc;
    logic err;
    err = TmoEn && (w >= int'(TMO));
    acc = err ? int'(TMO) : w + 1;
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wd;
    scramble_slave();
    @(posedge PCLK);
    m_write = wr;
    m_addr  = addr;
    m_wdata = wd;
    // Cycle 1 is SETUP, 2..1+acc are ACCESS, 2+acc carries the response.
    for (int k = 1; k <= 2 + acc; k++) begin
      @(negedge PCLK);
      if (k <= 1 + acc) begin
        check_eq("busy_psel", 32'(PSEL), 32'd1);
        check_eq("busy_penable", 32'(PENABLE), 32'(k >= 2));
        check_eq("busy_req_ready", 32'(req_ready), 32'd0);
        check_eq("busy_rsp_valid", 32'(rsp_valid), 32'd0);
        check_bus_hold();
        req_valid = 1'($urandom);
        scramble_req();
        if (k >= 2) begin
          PREADY = (k == 2 + w);
          PRDATA = (k == 2 + w) ? prd : DW'($urandom);
        end else begin
          scramble_slave();
        end
      end else begin
        m_rdata = (err || wr) ? '0 : prd;
        check_idle(1'b1, err);
      end
    end
  endtask

  // Reset asserted in ACCESS of a read, with PREADY high at the same edge.
  task automatic reset_in_access();
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 8'h56;
    req_wdata = 8'h00;
    @(posedge PCLK);
    m_write = 1'b0;
    m_addr  = 8'h56;
    m_wdata = 8'h00;
    @(negedge PCLK);
    req_valid = 1'b0;
    PREADY    = 1'b0;
    @(posedge PCLK);
    @(negedge PCLK);
    check_eq("rst_pre_penable", 32'(PENABLE), 32'd1);
    PRESET    = 1'b1;
    PREADY    = 1'b1;
    PRDATA    = 8'h77;
    req_valid = 1'b1;
    @(posedge PCLK);
    @(negedge PCLK);
    m_write = 1'b0;
    m_addr  = '0;
    m_wdata = '0;
    m_rdata = '0;
    check_idle(1'b0, 1'b0);
    PRESET    = 1'b0;
    req_valid = 1'b0;
    @(posedge PCLK);
    @(negedge PCLK);
    check_idle(1'b0, 1'b0);
  endtask

  initial begin
    PRESET    = 1'b1;
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 8'hFF;
    req_wdata = 8'hFF;
    PREADY    = 1'b1;
    PRDATA    = 8'hFF;
    m_write   = 1'b0;
    m_addr    = '0;
    m_wdata   = '0;
    m_rdata   = '0;
    repeat (2) @(posedge PCLK);
    @(negedge PCLK);
    check_idle(1'b0, 1'b0);
    PRESET = 1'b0;
    idle_cycle();

    // Zero-wait write, then a read with two wait states.
    txn(1'b1, 8'h12, 8'hA5, 0, 8'h3C);
    idle_cycle();
    txn(1'b0, 8'h34, 8'h99, 2, 8'h5C);

    // req_valid held high: each transfer follows its response cycle directly.
    txn(1'b0, 8'h01, 8'h11, 0, 8'hC3);
    txn(1'b1, 8'h02, 8'h22, 1, 8'hD4);
    txn(1'b0, 8'h03, 8'h33, 0, 8'hE5);
    idle_cycle();

    reset_in_access();

`ifdef APB_TIMEOUT_EN
    txn(1'b0, 8'h40, 8'h00, 20, 8'hAA);
    idle_cycle();
    txn(1'b0, 8'h41, 8'h00, int'(TMO) - 1, 8'hBB);
    idle_cycle();
`endif

    for (int i = 0; i < 60; i++) begin
      txn(1'($urandom), AW'($urandom), DW'($urandom),
          int'($urandom_range(0, TmoEn ? 6 : 3)), DW'($urandom));
      repeat ($urandom_range(0, 2)) idle_cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
